// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128 encryption, one round per key_expansion fetch.
// Define AES_KEY_WAIT_EXT_EN to add a second KWAIT cycle per key fetch for slow key settle.
module aes_cipher_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         start_enc,
  output logic         ready_enc,
  input  logic [127:0] key_enc,
  output logic         busy
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`ifdef AES_KEY_WAIT_EXT_EN
  typedef enum logic [5:0] {
    IDLE = 6'b000001, KSTART = 6'b000010, KREQ = 6'b000100,
    KWAIT = 6'b001000, KWAIT2 = 6'b010000, DONE = 6'b100000
  } state_e;
`else
  typedef enum logic [4:0] {
    IDLE = 5'b00001, KSTART = 5'b00010, KREQ = 5'b00100,
    KWAIT = 5'b01000, DONE = 5'b10000
  } state_e;
`endif
  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  state_e       st_q;
  logic [127:0] s_q, s_d, sr_v, mc_v;
  logic [3:0]   rnd_q;
  logic         in_ready_q, out_valid_q, start_q, req_q, busy_q;
  logic [7:0]   sb_w [16];
  logic [7:0]   sr_w [16];
  // Byte i sits at row i%4, column i/4; MixColumns row r = 2a_r ^ 3a_r+1 ^ a_r+2 ^ a_r+3.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign sb_w[i] = SBOX[s_q[127-8*i -: 8]];
    assign sr_w[i] = sb_w[R + 4*((C + R) % 4)];
    assign sr_v[127-8*i -: 8] = sr_w[i];
    assign mc_v[127-8*i -: 8] = xt(sr_w[4*C+R]) ^ xt(sr_w[4*C+(R+1)%4]) ^ sr_w[4*C+(R+1)%4]
                              ^ sr_w[4*C+(R+2)%4] ^ sr_w[4*C+(R+3)%4];
  end
  always_comb
    s_d = (rnd_q == 4'd0) ? s_q ^ key_enc : ((rnd_q == 4'd10) ? sr_v : mc_v) ^ key_enc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      s_q         <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            s_q        <= in_data;
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            st_q       <= KSTART;
          end
        end
        KSTART: begin
          start_q <= 1'b0;
          st_q    <= KWAIT;
        end
        KREQ: begin
          req_q <= 1'b0;
          st_q  <= KWAIT;
        end
`ifdef AES_KEY_WAIT_EXT_EN
        KWAIT: st_q <= KWAIT2;
        KWAIT2: begin
`else
        KWAIT: begin
`endif
          s_q   <= s_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            out_valid_q <= 1'b1;
            st_q        <= DONE;
          end else begin
            req_q <= 1'b1;
            st_q  <= KREQ;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            st_q        <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  // Gate the datapath so partial round state never appears on out_data.
  assign out_data  = out_valid_q ? s_q : '0;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign start_enc = start_q;
  assign ready_enc = req_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: scoreboard bench for aes_cipher_iter with a behavioural key_expansion.
module tb_aes_cipher_iter;
`ifdef AES_KEY_WAIT_EXT_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 22;
`endif
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, start_enc, ready_enc, busy;
  logic [127:0] out_data, key_enc;
  logic [127:0] rk [11];
  logic [127:0] sb [$];
  int           acc_q [$];
  int           kptr = 0, cyc = 0, n_acc = 0;
  int           n_cmp = 0, n_err = 0;
  int           st_rise = 0, st_cyc = 0, rq_rise = 0, rq_cyc = 0;
  logic         st_prev = 1'b0, rq_prev = 1'b0, ov_prev = 1'b0;

  aes_cipher_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .start_enc(start_enc), .ready_enc(ready_enc), .key_enc(key_enc), .busy(busy)
  );

  always #5 clk = ~clk;

  // key_expansion model: start_enc rewinds to round 0, each ready_enc rise advances.
  assign key_enc = rk[kptr];
  always @(posedge start_enc or posedge ready_enc)
    kptr <= start_enc ? 0 : (kptr < 10 ? kptr + 1 : kptr);

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct);
    int b;
    b = 0;
    sb.push_back(ct);
    in_data  = pt;
    in_valid = 1'b1;
    while (!in_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 128'hdeadbeef_cafef00d_0badc0de_55aa55aa;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d blocks outstanding, required 0", sb.size());
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc);
      n_acc++;
    end
    if (rst_n && out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
    cyc <= cyc + 1;
  end

  // Monitor: checks latency on the out_valid rise and the presented block every DONE cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      st_prev = 1'b0;
      rq_prev = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (start_enc) begin st_cyc++; if (!st_prev) st_rise++; end
      if (ready_enc) begin rq_cyc++; if (!rq_prev) rq_rise++; end
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          n_err++;
          $display("FAIL latency: out_valid rose with no accepted block");
        end else chk("latency", 128'(cyc - 1 - acc_q.pop_front()), 128'(LAT));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %h with no block expected", out_data);
        end else begin
          chk("out_data", out_data, sb[0]);
          chk("busy_done", 128'(busy), 128'(1));
          chk("in_ready_done", 128'(in_ready), 128'(0));
        end
      end
      st_prev = start_enc;
      rq_prev = ready_enc;
      ov_prev = out_valid;
    end
  end

  initial begin
    int s0, sc0, r0, rc0, a0, b;
    set_key(K1);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_start", 128'(start_enc), 128'(0));
    chk("rst_ready", 128'(ready_enc), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    chk("idle_busy", 128'(busy), 128'(0));
    send(P1, C1);
    drain();
    set_key(K2);
    send(P2, C2);
    send(P2, C2);
    drain();
    // Pulse audit: in_valid held high across three blocks.
    s0 = st_rise; sc0 = st_cyc; r0 = rq_rise; rc0 = rq_cyc; a0 = n_acc;
    repeat (3) sb.push_back(C2);
    in_data  = P2;
    in_valid = 1'b1;
    b = 0;
    while (n_acc - a0 < 3 && b < 200) begin
      @(negedge clk);
      b++;
    end
    in_valid = 1'b0;
    drain();
    chk("accepts", 128'(n_acc - a0), 128'(3));
    chk("start_pulses", 128'(st_rise - s0), 128'(3));
    chk("start_cycles", 128'(st_cyc - sc0), 128'(3));
    chk("ready_pulses", 128'(rq_rise - r0), 128'(30));
    chk("ready_cycles", 128'(rq_cyc - rc0), 128'(30));
    // Back-pressure.
    out_ready = 1'b0;
    send(P2, C2);
    b = 0;
    while (!out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    repeat (15) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_out_valid", 128'(out_valid), 128'(0));
    chk("handoff_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    drain();
    // Reset mid-block at E9.
    set_key(K1);
    send(P1, C1);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_in_ready", 128'(in_ready), 128'(0));
    chk("mid_out_valid", 128'(out_valid), 128'(0));
    chk("mid_out_data", out_data, 128'(0));
    chk("mid_start", 128'(start_enc), 128'(0));
    chk("mid_ready", 128'(ready_enc), 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    sb.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(P1, C1);
    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
